vram_px_fill: RTL and testbench
===============================

Name: vram_px_fill

Overview:
- Rectangle-fill engine upstream of the FSX pixel plane.
- Accepts a fill command (origin, size, colour) and writes VRAMPX one byte per clock through the VRAMPX write port.
- FSX reads that plane through the opposite port.
- Optionally holds the command until the next frameDrawn pulse, so fills land in vertical blank and do not tear.

Parameters:
- PX_W, 320, pixel-plane width in pixels
- PX_H, 240, pixel-plane height in lines
- ADDR_BITS, 17, VRAMPX address width (PX_W*PX_H = 76800 words)

Ports:
- clk  in  1  single clock, same domain as the VRAMPX write port
- nreset  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe
- x  in  9  left column
- y  in  8  top line
- w  in  9  width in pixels
- h  in  8  height in lines
- color  in  8  RGB332 fill value
- vsync_wait  in  1  1 = defer the fill until the next frameDrawn rising edge
- frameDrawn  in  1  FSX end-of-frame pulse
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle rejected-command pulse
- vramPX_addr  out  ADDR_BITS  write address
- vramPX_d  out  8  write data
- vramPX_we  out  1  write enable

Behaviour:
- Reset is asynchronous and active-low on nreset. All outputs go to 0 and the FSM goes to IDLE immediately, including mid-fill. A partially written rectangle is left as is.
- FSM states: IDLE, WAITV, FILL, DONE.
- IDLE, start=1:
  - If x>=PX_W, y>=PX_H, w==0 or h==0: assert err for one cycle (the next cycle), stay IDLE, no write.
  - Otherwise latch the command and set busy=1 on the next cycle.
  - Clip: wc = min(w, PX_W-x), hc = min(h, PX_H-y).
  - Go to WAITV if vsync_wait=1, else FILL.
- start while busy is ignored. No queueing, no err.
- WAITV:
  - frameDrawn is registered once inside the block; rising edge = reg low and current input high.
  - On the edge go to FILL.
  - A frameDrawn already high at start does not count as an edge.
- FILL:
  - One write per cycle: vramPX_we=1, vramPX_d=latched colour.
  - Address = row_base + col. row_base starts at y*PX_H-independent y*PX_W, computed as (y<<8)+(y<<6) for the default width; no generic multiplier.
  - col counts 0..wc-1. At wrap, col=0 and row_base += PX_W.
  - On the write of pixel (wc-1, hc-1) go to DONE.
- DONE: we=0, done=1 for one cycle, busy=0 on the following cycle, return to IDLE. start in the DONE cycle is ignored.
- Latency with vsync_wait=0: start at cycle N; first write at N+1; last write at N+wc*hc; done at N+wc*hc+1.
- Outputs are registered, not combinational from the inputs. vramPX_addr and vramPX_d hold their last value when we=0.
- Address never exceeds PX_W*PX_H-1, guaranteed by clipping.

Decomposition:
- Shared package gpu_px_pkg holds PX_W, PX_H, PX_ADDR_BITS and the state encoding. The FSX read side uses the same constants.
- No sub-module. Address generator and FSM are in one module.

Test Plan:
- x=0,y=0,w=4,h=2,color=0xE0,vsync_wait=0 → 8 consecutive writes at addr 0,1,2,3,320,321,322,323 with data 0xE0; busy for 9 cycles; done one cycle after the last write.
- x=318,y=239,w=10,h=10 → clipped to 2x1: writes at 76798 and 76799 only, then done.
- x=320,y=5,w=1,h=1, then w=0 → err pulse each time, no we, busy stays 0.
- vsync_wait=1 with frameDrawn held high at start → no write until frameDrawn drops and rises again; first write one cycle after the registered rising edge.
- Second start mid-fill with different colour → ignored; write count and data match the first command only.
- nreset low in the middle of a 16x16 fill → we, busy and done drop asynchronously. After release a new 1x1 fill at (5,5) writes addr 1605 and completes normally.

Source files
------------

// File: rtl/gpu_px_pkg.sv
// Shared pixel-plane geometry and fill-engine state encoding.
// The FSX read side uses the same geometry constants.
package gpu_px_pkg;

  localparam int unsigned PX_W         = 320;
  localparam int unsigned PX_H         = 240;
  localparam int unsigned PX_ADDR_BITS = 17;
  localparam int unsigned X_BITS       = 9;
  localparam int unsigned Y_BITS       = 8;
  localparam int unsigned COLOR_BITS   = 8;

  localparam logic [X_BITS-1:0]       PX_W_X = X_BITS'(PX_W);
  localparam logic [Y_BITS-1:0]       PX_H_Y = Y_BITS'(PX_H);
  localparam logic [PX_ADDR_BITS-1:0] PX_W_A = PX_ADDR_BITS'(PX_W);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAITV = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // y*320 as two shifts; only valid for the default plane width.
  function automatic logic [PX_ADDR_BITS-1:0] row_base(input logic [Y_BITS-1:0] y);
    return (PX_ADDR_BITS'(y) << 8) + (PX_ADDR_BITS'(y) << 6);
  endfunction

endpackage

// File: rtl/vram_px_fill.sv
// Rectangle-fill engine: writes one clipped pixel per clock into VRAMPX,
// optionally deferred to the next frameDrawn rising edge.
module vram_px_fill
  import gpu_px_pkg::*;
(
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    start,
  input  logic [X_BITS-1:0]       x,
  input  logic [Y_BITS-1:0]       y,
  input  logic [X_BITS-1:0]       w,
  input  logic [Y_BITS-1:0]       h,
  input  logic [COLOR_BITS-1:0]   color,
  input  logic                    vsync_wait,
  input  logic                    frameDrawn,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [PX_ADDR_BITS-1:0] vramPX_addr,
  output logic [COLOR_BITS-1:0]   vramPX_d,
  output logic                    vramPX_we
);

  logic [1:0]              state_q, state_d;
  logic                    busy_q, busy_d, done_q, done_d, err_q, err_d, we_q, we_d;
  logic                    fd_q;
  logic [PX_ADDR_BITS-1:0] addr_q, addr_d, base_q, base_d;
  logic [COLOR_BITS-1:0]   d_q, d_d, color_q, color_d;
  logic [X_BITS-1:0]       wc_q, wc_d, col_q, col_d;
  logic [Y_BITS-1:0]       hc_q, hc_d, row_q, row_d;

  logic                    bad_c;
  logic [X_BITS-1:0]       avail_x_c, wc_c;
  logic [Y_BITS-1:0]       avail_y_c, hc_c;
  logic [PX_ADDR_BITS-1:0] start_base_c;

  // Command validation and clipping against the plane edges.
  always_comb begin
    bad_c        = (x >= PX_W_X) || (y >= PX_H_Y) || (w == '0) || (h == '0);
    avail_x_c    = PX_W_X - x;
    avail_y_c    = PX_H_Y - y;
    wc_c         = (w < avail_x_c) ? w : avail_x_c;
    hc_c         = (h < avail_y_c) ? h : avail_y_c;
    start_base_c = row_base(y) + PX_ADDR_BITS'(x);
  end

  // Next-state and registered-output logic; addr_q always shows the pixel being written.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    d_d     = d_q;
    color_d = color_q;
    wc_d    = wc_q;
    hc_d    = hc_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (bad_c) begin
            err_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            wc_d    = wc_c;
            hc_d    = hc_c;
            col_d   = '0;
            row_d   = '0;
            base_d  = start_base_c;
            color_d = color;
            if (vsync_wait) begin
              state_d = ST_WAITV;
            end else begin
              state_d = ST_FILL;
              we_d    = 1'b1;
              addr_d  = start_base_c;
              d_d     = color;
            end
          end
        end
      end
      ST_WAITV: begin
        if (!fd_q && frameDrawn) begin
          state_d = ST_FILL;
          we_d    = 1'b1;
          addr_d  = base_q;
          d_d     = color_q;
        end
      end
      ST_FILL: begin
        if (col_q == wc_q - X_BITS'(1)) begin
          if (row_q == hc_q - Y_BITS'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            col_d  = '0;
            row_d  = row_q + Y_BITS'(1);
            base_d = base_q + PX_W_A;
            addr_d = base_q + PX_W_A;
            we_d   = 1'b1;
          end
        end else begin
          col_d  = col_q + X_BITS'(1);
          addr_d = base_q + PX_ADDR_BITS'(col_q + X_BITS'(1));
          we_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      fd_q    <= 1'b0;
      addr_q  <= '0;
      d_q     <= '0;
      color_q <= '0;
      wc_q    <= '0;
      hc_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      fd_q    <= frameDrawn;
      addr_q  <= addr_d;
      d_q     <= d_d;
      color_q <= color_d;
      wc_q    <= wc_d;
      hc_q    <= hc_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign vramPX_we   = we_q;
  assign vramPX_addr = addr_q;
  assign vramPX_d    = d_q;

endmodule

// File: tb/tb_vram_px_fill.sv
// Self-checking bench for vram_px_fill: write scoreboard plus per-scenario checks.
module tb_vram_px_fill;

  typedef struct packed {
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  x = '0;
  logic [7:0]  y = '0;
  logic [8:0]  w = '0;
  logic [7:0]  h = '0;
  logic [7:0]  color = '0;
  logic        vsync_wait = 1'b0;
  logic        frameDrawn = 1'b0;
  logic        busy, done, err, vramPX_we;
  logic [16:0] vramPX_addr;
  logic [7:0]  vramPX_d;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  wr_t exp_q[$];

  vram_px_fill dut (
    .clk(clk), .nreset(nreset), .start(start), .x(x), .y(y), .w(w), .h(h),
    .color(color), .vsync_wait(vsync_wait), .frameDrawn(frameDrawn),
    .busy(busy), .done(done), .err(err), .vramPX_addr(vramPX_addr),
    .vramPX_d(vramPX_d), .vramPX_we(vramPX_we)
  );

  always #5 clk = ~clk;

  // Scoreboard: every write is popped against the model's expected sequence.
  always @(negedge clk) begin
    if (nreset && vramPX_we) begin
      wr_t e;
      n_writes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d data=%02h, none expected", vramPX_addr, vramPX_d);
      end else begin
        e = exp_q.pop_front();
        if (vramPX_addr !== e.a || vramPX_d !== e.d) begin
          n_fail++;
          $display("FAIL write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                   vramPX_addr, vramPX_d, e.a, e.d);
        end
      end
    end
  end

  // Pulse start for one cycle; optionally push the model's clipped write list.
  task automatic issue(input int xi, input int yi, input int wi, input int hi,
                       input int ci, input bit vw, input bit push);
    int wc, hc;
    @(negedge clk);
    x = 9'(xi); y = 8'(yi); w = 9'(wi); h = 8'(hi); color = 8'(ci); vsync_wait = vw;
    start = 1'b1;
    if (push) begin
      wc = (wi < 320 - xi) ? wi : 320 - xi;
      hc = (hi < 240 - yi) ? hi : 240 - yi;
      for (int r = 0; r < hc; r++)
        for (int c = 0; c < wc; c++)
          exp_q.push_back('{a: 17'((yi + r) * 320 + xi + c), d: 8'(ci)});
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({busy, done, err, vramPX_we} !== 4'b0 || vramPX_addr !== '0 || vramPX_d !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b we=%b addr=%0d d=%02h, all must be 0",
               busy, done, err, vramPX_we, vramPX_addr, vramPX_d);
    end
    @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int busy_cnt = 0, done_cnt = 0, first_we = -1, last_we = -1, done_at = -1;
    issue(0, 0, 4, 2, 8'hE0, 1'b0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = i; end
      if (vramPX_we) begin
        if (first_we < 0) first_we = i;
        last_we = i;
      end
    end
    n_checks++;
    if (busy_cnt != 9) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d, expected 9", busy_cnt); end
    n_checks++;
    if (first_we != 1) begin n_fail++; $display("FAIL basic_first_write: cycle %0d, expected 1", first_we); end
    n_checks++;
    if (last_we != 8) begin n_fail++; $display("FAIL basic_last_write: cycle %0d, expected 8", last_we); end
    n_checks++;
    if (done_at != 9 || done_cnt != 1) begin
      n_fail++; $display("FAIL basic_done: at %0d count %0d, expected at 9 count 1", done_at, done_cnt);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_drain: %0d writes missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_clip;
    bit seen;
    int w0 = n_writes;
    issue(318, 239, 10, 10, 8'h1C, 1'b0, 1'b1);
    wait_done(20, seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL clip_done: done=0, expected 1 within 20 cycles"); end
    n_checks++;
    if (n_writes - w0 != 2) begin n_fail++; $display("FAIL clip_count: got %0d writes, expected 2", n_writes - w0); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL clip_drain: %0d writes missing, expected 0", exp_q.size()); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_err;
    int cx[4] = '{320, 5, 5, 0};
    int cy[4] = '{5, 5, 5, 240};
    int cw[4] = '{1, 0, 3, 1};
    int ch[4] = '{1, 1, 0, 1};
    for (int k = 0; k < 4; k++) begin
      int w0 = n_writes;
      issue(cx[k], cy[k], cw[k], ch[k], 8'hFF, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL err_pulse case %0d: err=%b busy=%b, expected err=1 busy=0", k, err, busy);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b0 || n_writes != w0) begin
        n_fail++;
        $display("FAIL err_after case %0d: err=%b busy=%b writes=%0d, expected 0 0 0", k, err, busy, n_writes - w0);
      end
    end
  endtask

  task automatic test_vsync;
    bit seen;
    int w0;
    @(negedge clk);
    frameDrawn = 1'b1;
    issue(0, 10, 3, 1, 8'h55, 1'b1, 1'b1);
    w0 = n_writes;
    repeat (5) @(negedge clk);
    frameDrawn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_writes != w0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL vsync_hold: writes=%0d busy=%b, expected 0 writes busy=1", n_writes - w0, busy);
    end
    frameDrawn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (vramPX_we !== 1'b1) begin n_fail++; $display("FAIL vsync_first_write: we=%b, expected 1", vramPX_we); end
    frameDrawn = 1'b0;
    wait_done(10, seen);
    n_checks++;
    if (!seen || exp_q.size() != 0) begin
      n_fail++; $display("FAIL vsync_done: done_seen=%b missing=%0d, expected 1 and 0", seen, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit seen;
    int w0 = n_writes;
    issue(10, 20, 5, 2, 8'hAA, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    issue(50, 50, 7, 7, 8'h33, 1'b0, 1'b0);
    wait_done(20, seen);
    n_checks++;
    if (!seen || n_writes - w0 != 10 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ignore_busy_start: done=%b writes=%0d missing=%0d, expected 1 10 0", seen, n_writes - w0, exp_q.size());
    end
    // start held during the done cycle must also be dropped
    start = 1'b1; x = 9'd1; y = 8'd1; w = 9'd1; h = 8'd1; vsync_wait = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    w0 = n_writes;
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || n_writes != w0) begin
      n_fail++; $display("FAIL ignore_done_start: busy=%b writes=%0d, expected 0 0", busy, n_writes - w0);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    int w0;
    issue(0, 0, 16, 16, 8'h0F, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 nreset = 1'b0;
    #1;
    n_checks++;
    if (vramPX_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: we=%b busy=%b done=%b, expected 0 0 0", vramPX_we, busy, done);
    end
    exp_q.delete();
    @(negedge clk);
    nreset = 1'b1;
    w0 = n_writes;
    issue(5, 5, 1, 1, 8'h77, 1'b0, 1'b1);
    wait_done(10, seen);
    n_checks++;
    if (!seen || n_writes - w0 != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL post_reset_fill: done=%b writes=%0d missing=%0d, expected 1 1 0", seen, n_writes - w0, exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_clip;
    test_err;
    test_vsync;
    test_back_to_back;
    test_reset_mid;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
